// File: rtl/writeback_arbiter_pkg.sv
// Shared constants and types for the writeback arbiter and its load buffer.
// Defining WB_STARVE_GUARD_EN at build time enables load-starvation protection in the arbiter.
package writeback_arbiter_pkg;

   localparam int REG_COUNT_DEFAULT    = 8;
   localparam int REG_SIZE_DEFAULT     = 16;
   localparam int REG_PTR_SIZE_DEFAULT = 4;
   localparam int LQ_DEPTH_DEFAULT     = 2;

   // Consecutive ALU wins over a waiting load before the load is forced through
   localparam int STARVE_LIMIT = 3;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_ALU,
      SEL_LOAD
   } wb_sel_e;

endpackage

// File: rtl/writeback_arbiter_load_fifo.sv
// Circular FIFO holding returned loads until the single register-file write port is free.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_load_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       data_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_q, wr_q;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_q];

   // Overflow and underflow requests are dropped rather than corrupting the pointers
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) begin
            wr_q <= wr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_q <= rd_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Single-port register-file writeback arbiter: ALU results beat buffered loads, with a pending-write scoreboard.
// Build macro WB_STARVE_GUARD_EN forces a buffered load through after a run of ALU wins (alu_stall).
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int REG_COUNT    = REG_COUNT_DEFAULT,
   parameter int REG_SIZE     = REG_SIZE_DEFAULT,
   parameter int REG_PTR_SIZE = REG_PTR_SIZE_DEFAULT,
   parameter int LQ_DEPTH     = LQ_DEPTH_DEFAULT
) (
   input  logic                    clk,
   input  logic                    reset_WB,
   input  logic                    alu_valid,
   input  logic [REG_PTR_SIZE-1:0] alu_dst,
   input  logic [REG_SIZE-1:0]     alu_data,
   input  logic                    ld_valid,
   output logic                    ld_ready,
   input  logic [REG_PTR_SIZE-1:0] ld_dst,
   input  logic [REG_SIZE-1:0]     ld_data,
   input  logic                    issue_valid,
   input  logic [REG_PTR_SIZE-1:0] issue_dst,
   input  logic [REG_PTR_SIZE-1:0] FD_insn_src_0,
   input  logic [REG_PTR_SIZE-1:0] FD_insn_src_1,
   output logic                    D_hazard,
   output logic [REG_SIZE-1:0]     W_result,
   output logic [REG_PTR_SIZE-1:0] MW_insn_dst,
   output logic                    MW_insn_is_F1,
   output logic                    MW_insn_is_F2,
   output logic [REG_COUNT-1:0]    pending,
   output logic                    err_wb,
   output logic                    alu_stall
);

   localparam int ENTRY_W = REG_PTR_SIZE + REG_SIZE;
   localparam int CNT_W   = $clog2(LQ_DEPTH) + 1;
   // Shifting this past REG_COUNT yields zero, so out-of-range pointers produce empty masks
   localparam logic [REG_COUNT-1:0] ONE = REG_COUNT'(1);

   logic                    lq_push, lq_pop, lq_full, lq_empty;
   logic [CNT_W-1:0]        lq_count;
   logic [ENTRY_W-1:0]      lq_head;

   wb_sel_e                 sel;
   logic [REG_PTR_SIZE-1:0] sel_dst;
   logic [REG_SIZE-1:0]     sel_data;

   logic [REG_COUNT-1:0]    set_mask, clr_mask;
   logic [REG_COUNT-1:0]    pending_q, pending_d;
   logic                    wr_valid_q, wr_valid_d;
   logic [REG_PTR_SIZE-1:0] wr_dst_q, wr_dst_d;
   logic [REG_SIZE-1:0]     wr_data_q, wr_data_d;
   logic                    err_q, err_d;

   assign ld_ready = (int'(lq_count) < LQ_DEPTH);
   assign lq_push  = ld_valid && ld_ready && !lq_full;

   wb_load_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (LQ_DEPTH)
   ) u_load_fifo (
      .clk_i   (clk),
      .reset_i (reset_WB),
      .push_i  (lq_push),
      .pop_i   (lq_pop),
      .data_i  ({ld_dst, ld_data}),
      .data_o  (lq_head),
      .full_o  (lq_full),
      .empty_o (lq_empty),
      .count_o (lq_count)
   );

`ifdef WB_STARVE_GUARD_EN
   logic [1:0] starve_q, starve_d;

   // Counts consecutive cycles where a load waits while the ALU takes the port
   assign alu_stall = (starve_q == 2'(STARVE_LIMIT)) && !lq_empty;

   always_comb begin
      starve_d = '0;
      if (!alu_stall && alu_valid && !lq_empty) begin
         starve_d = starve_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_WB) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign alu_stall = 1'b0;
`endif

   always_comb begin
      sel      = SEL_NONE;
      sel_dst  = lq_head[ENTRY_W-1:REG_SIZE];
      sel_data = lq_head[REG_SIZE-1:0];
      if (alu_valid && !alu_stall) begin
         sel      = SEL_ALU;
         sel_dst  = alu_dst;
         sel_data = alu_data;
      end else if (!lq_empty) begin
         sel = SEL_LOAD;
      end
   end

   assign lq_pop = (sel == SEL_LOAD);

   // The clear lands on the same edge that loads the write register, so pending drops as the write is presented
   always_comb begin
      set_mask   = issue_valid ? (ONE << issue_dst) : '0;
      clr_mask   = (sel != SEL_NONE) ? (ONE << sel_dst) : '0;
      pending_d  = (pending_q & ~clr_mask) | set_mask;

      wr_valid_d = (sel != SEL_NONE);
      wr_dst_d   = wr_valid_d ? sel_dst : wr_dst_q;
      wr_data_d  = wr_valid_d ? sel_data : wr_data_q;

      err_d = err_q;
      if (issue_valid && ((set_mask == '0) || (|(pending_q & set_mask & ~clr_mask)))) begin
         err_d = 1'b1;
      end
      if (wr_valid_d && !(|(pending_q & clr_mask))) begin
         err_d = 1'b1;
      end
      if (ld_valid && alu_stall) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_WB) begin
         pending_q  <= '0;
         wr_valid_q <= 1'b0;
         wr_dst_q   <= '0;
         wr_data_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         wr_valid_q <= wr_valid_d;
         wr_dst_q   <= wr_dst_d;
         wr_data_q  <= wr_data_d;
         err_q      <= err_d;
      end
   end

   assign D_hazard      = |(pending_q & ((ONE << FD_insn_src_0) | (ONE << FD_insn_src_1)));
   assign W_result      = wr_data_q;
   assign MW_insn_dst   = wr_dst_q;
   assign MW_insn_is_F1 = wr_valid_q;
   assign MW_insn_is_F2 = 1'b0;
   assign pending       = pending_q;
   assign err_wb        = err_q;

endmodule
